// File: rtl/mult_result_queue_tainttrack_if.sv
// Result stream from the taint-tracked multiplier queue to its consumer.
// The master (the queue) drives valid/data and their shadow taint. The slave
// (the consumer) drives ready and its taint.
interface mult_result_queue_tainttrack_if #(
    parameter int DATA_W = 8192
);
    logic              out_valid;
    logic              out_valid_t;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_data_t;
    logic              out_ready;
    logic              out_ready_t;

    modport master (
        output out_valid, out_valid_t, out_data, out_data_t,
        input  out_ready, out_ready_t
    );

    modport slave (
        input  out_valid, out_valid_t, out_data, out_data_t,
        output out_ready, out_ready_t
    );
endinterface

// File: rtl/mult_result_queue_tainttrack.sv
// Result queue downstream of the taint-tracked multiplier.
// A rising edge on productDone captures the product into a small FIFO. Queued
// products go to the consumer over a valid/ready handshake. Every data and
// control bit carries shadow taint. state_t_kill clears control taint only.
// Optional feature macro: MULT_RESULT_DROP_OLDEST_EN. When it is defined, a
// capture into a full queue with no pop replaces the oldest entry. When it is
// undefined, that capture is dropped. overflow is set in both builds.
module mult_result_queue_tainttrack #(
    parameter int WIDTH = 4096,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 productDone,
    input  logic                 productDone_t,
    input  logic [2*WIDTH-1:0]   product,
    input  logic [2*WIDTH-1:0]   product_t,
    input  logic                 state_t_kill,
    mult_result_queue_tainttrack_if.master res,
    output logic                 full,
    output logic                 full_t,
    output logic                 overflow,
    output logic                 overflow_t
);
    localparam int DW    = 2 * WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DW-1:0]    mem   [DEPTH];
    logic [DW-1:0]    mem_t [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             done_q;
    logic             done_q_t;
    logic             ctl_t;
    logic             overflow_r;
    logic             overflow_t_r;

    logic cap;
    logic valid;
    logic is_full;
    logic pop;
    logic push;
    logic lost;
    logic wr_en;
    logic head_adv;
    logic ctl_t_set;

    assign cap     = productDone & ~done_q;
    assign valid   = (count != '0);
    assign is_full = (count == CNT_FULL);
    assign pop     = valid & res.out_ready;
    assign push    = cap & (~is_full | pop);
    assign lost    = cap & is_full & ~pop;

`ifdef MULT_RESULT_DROP_OLDEST_EN
    // A lost capture still writes the slot under tail. Because the queue is
    // full, that slot holds the oldest entry, so both pointers move forward.
    assign wr_en    = push | lost;
    assign head_adv = pop | lost;
`else
    assign wr_en    = push;
    assign head_adv = pop;
`endif

    // A control decision is tainted when the edge detector or the pop
    // handshake depended on a tainted input.
    assign ctl_t_set = productDone_t | done_q_t | (valid & res.out_ready_t);

    // Entry storage has no reset. Reads are masked by the count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail]   <= product;
            mem_t[tail] <= product_t;
        end
    end

    // Pointers, occupancy, edge detect and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            done_q     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_q <= productDone;
            if (wr_en)
                tail <= tail + PTR_W'(1);
            if (head_adv)
                head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (lost)
                overflow_r <= 1'b1;
        end
    end

    // Shadow taint for control state. Kill overrides a set in the same cycle.
    // overflow_t is cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_t        <= 1'b0;
            done_q_t     <= 1'b0;
            overflow_t_r <= 1'b0;
        end else begin
            if (state_t_kill) begin
                ctl_t    <= 1'b0;
                done_q_t <= 1'b0;
            end else begin
                ctl_t    <= ctl_t | ctl_t_set;
                done_q_t <= productDone_t;
            end
            if (lost && (ctl_t || productDone_t || done_q_t))
                overflow_t_r <= 1'b1;
        end
    end

    assign res.out_valid   = valid;
    assign res.out_valid_t = ctl_t;
    assign res.out_data    = valid ? mem[head] : '0;
    assign res.out_data_t  = (valid ? mem_t[head] : '0) | {DW{ctl_t}};
    assign full            = is_full;
    assign full_t          = ctl_t;
    assign overflow        = overflow_r;
    assign overflow_t      = overflow_t_r;

endmodule

// File: doc/mult_result_queue_tainttrack.md
Name: mult_result_queue_tainttrack

Overview:
- Downstream stage of the taint-tracked multiplier. Captures each finished product on the rising edge of productDone and queues it in a small FIFO.
- Delivers queued products to the consumer over a valid/ready handshake.
- Carries shadow taint alongside every data and control bit. state_t_kill clears control-path taint, with the same semantics as the multiplier control.

Parameters:
- WIDTH, 4096, multiplier operand width; product and queue entries are 2*WIDTH bits.
- DEPTH, 2, queue entries; power of two, >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- productDone  input  1  multiplier done flag; may stay high for several cycles
- productDone_t  input  1  taint of productDone
- product  input  2*WIDTH  multiplier result
- product_t  input  2*WIDTH  taint of product
- state_t_kill  input  1  synchronous clear of control taint
- out_ready  input  1  consumer accepts head entry
- out_ready_t  input  1  taint of out_ready
- out_valid  output  1  head entry valid
- out_valid_t  output  1  taint of out_valid
- out_data  output  2*WIDTH  head entry
- out_data_t  output  2*WIDTH  taint of out_data
- full  output  1  count == DEPTH
- full_t  output  1  taint of full
- overflow  output  1  sticky: a capture was lost
- overflow_t  output  1  taint of overflow

Behaviour:
- Reset (rst low, async): head, tail, count = 0; done_q = 0; all taint registers = 0; overflow = 0. Outputs: out_valid=0, full=0, out_data=0, all *_t = 0. Entry storage need not be reset.
- Edge detect: done_q <= productDone every cycle. cap = productDone & ~done_q. A single long productDone pulse yields exactly one capture.
- Push: cap and (count < DEPTH or pop this cycle) -> mem[tail] <= product, mem_t[tail] <= product_t, tail++ (wraps mod DEPTH).
- Pop: out_valid & out_ready -> head++ (wraps).
- count: +1 on push only, -1 on pop only, unchanged on push+pop.
- Full with simultaneous pop: push succeeds, count stays DEPTH.
- Latency: capture edge at cycle N -> out_valid=1 and out_data=product at N+1 when queue was empty. No bypass.
- Full without pop: capture dropped, overflow <= 1. overflow is sticky until reset.
- out_valid = (count != 0). out_data = mem[head] when valid, else 0. full = (count == DEPTH).
- Control taint: ctl_t is a single register covering head, tail and count.
  - Set next cycle when a tainted decision occurs: cap evaluated with (productDone_t | done_q_t), or pop evaluated with out_valid & out_ready_t.
  - done_q_t <= productDone_t.
  - state_t_kill=1: ctl_t and done_q_t <= 0. Kill wins over a same-cycle set.
  - Entry taint mem_t is never cleared by kill.
- Output taint:
  - out_valid_t = full_t = ctl_t.
  - out_data_t = (out_valid ? mem_t[head] : 0) | {2*WIDTH{ctl_t}}.
  - overflow_t is set, sticky, when overflow is set in a cycle with tainted control (ctl_t | productDone_t | done_q_t). Cleared by reset only, not by kill.

Optional Feature:
- Macro: MULT_RESULT_DROP_OLDEST_EN.
- Defined: a capture while full without pop overwrites the oldest entry. mem[tail] is written, head and tail both advance, count stays DEPTH, overflow is still set.
- Undefined: the new capture is dropped and the queue is unchanged (default).

Test Plan (WIDTH=4, DEPTH=2):
- Reset then idle -> out_valid=0, full=0, out_data=8'h00, all taints 0. Assert rst low mid-queue with 2 entries -> immediately out_valid=0, count 0.
- productDone held high 3 cycles with product=8'h2A, product_t=0 -> exactly one entry; out_valid=1 next cycle, out_data=8'h2A; out_ready=1 pops it; out_valid=0.
- Three captures 8'h11, 8'h22, 8'h33, out_ready=0 -> full=1, overflow=1, queue holds 11,22. Drains 11 then 22. With MULT_RESULT_DROP_OLDEST_EN: drains 22 then 33.
- Full queue, capture 8'h44 same cycle as pop -> no overflow, count stays 2, later drains 22 then 44.
- Capture with product_t=8'h0F, productDone_t=0 -> out_data_t=8'h0F, out_valid_t=0.
- Capture with productDone_t=1 -> out_valid_t=1, out_data_t=8'hFF. Pulse state_t_kill -> out_valid_t=0 next cycle, out_data_t reverts to the entry taint.
